rtc_bus_cycle_engine: RTL and testbench
=======================================

# rtc_bus_cycle_engine

Generates one complete multiplexed address/data bus cycle to the external RTC chip per request: address phase, then a read or write data phase, with programmable strobe and hold widths. It sits directly downstream of the general RTC FSM, which supplies address, direction and write data, and upstream of the RTC pins (`a_d`, `cs`, `rd`, `wr`, `dato`). Read data is returned registered with a one-cycle `done` pulse. The top level builds the tri-state `dato` buffer from `dato_out`/`dato_oe`.

## Interface
- `PHASE_CYC`, 10: strobe width in clk cycles for both the address phase and the data phase; legal range 1..255.
- `HOLD_CYC`, 4: hold/recovery width in clk cycles after each strobe; legal range 1..255.
- `clk`  in  1  single system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `w_r`  in  1  1 = write to RTC, 0 = read from RTC.
- `addr`  in  8  RTC register address.
- `wdata`  in  8  write data.
- `dato_in`  in  8  pin value of `dato`.
- `dato_out`  out  8  value driven onto `dato`.
- `dato_oe`  out  1  1 = drive `dato`.
- `a_d`, `cs`, `rd`, `wr`  out  1 each  RTC strobes, all active-low.
- `rdata`  out  8  last captured read byte.
- `busy`  out  1  high in every non-IDLE state.
- `done`  out  1  one-cycle pulse at cycle end.
- `err`  out  1  one-cycle pulse (only with `RTC_BUS_BUSY_ERR_EN`).

## Operation
- All outputs registered. Reset values: `a_d`=`cs`=`rd`=`wr`=1, `dato_oe`=0, `dato_out`=0, `rdata`=0, `busy`=0, `done`=0, `err`=0. State IDLE.
- IDLE: strobes high, `dato_oe`=0. On `start`=1, latch `addr`, `wdata`, `w_r`; go to ADDR.
- ADDR (PHASE_CYC cycles): `a_d`=0, `cs`=0, `wr`=0, `dato_oe`=1, `dato_out`=latched addr.
- ADDR_HOLD (HOLD_CYC): `cs`=1, `wr`=1, `a_d`=0, addr still driven.
- DATA (PHASE_CYC): `a_d`=1, `cs`=0. Write: `wr`=0, `dato_oe`=1, `dato_out`=latched wdata. Read: `rd`=0, `dato_oe`=0; `rdata` loads `dato_in` on the clock edge that ends DATA.
- DATA_HOLD (HOLD_CYC): `cs`=`rd`=`wr`=1, `a_d`=1. Write keeps data driven. Read keeps `dato_oe`=0.
- DONE (1 cycle): all strobes high, `dato_oe`=0, `done`=1. Next state is IDLE. A new `start` is not accepted in DONE.
- `start` outside IDLE is ignored. Latched request fields never change mid-cycle.
- `rdata` holds its value across write cycles and between cycles.
- Phase timer: 8-bit down-counter, loaded with N-1 on phase entry; advance when it reaches 0.

## Timing
- Start sampled at edge k. ADDR outputs are visible from edge k+1.
- `done` is high in cycle k+1+2·PHASE_CYC+2·HOLD_CYC. Back-to-back `start` is accepted at the earliest one cycle later (IDLE).
- `busy` rises at k+1 and falls with the edge after `done`.
- `dato_oe` never changes in the same cycle as `rd` falling. On reads it is already 0 from the first DATA cycle.
- Reset asserted mid-cycle: outputs return to reset values immediately (async) and the state goes to IDLE. `done` is not issued.

## Configuration
- `RTC_BUS_BUSY_ERR_EN` defined: `start`=1 in any non-IDLE state pulses `err` for one cycle. The request is still dropped.
- Undefined: `err` is tied to 0 and no detection logic is built.

## Structure
- Package `rtc_bus_pkg`: state enum (IDLE, ADDR, ADDR_HOLD, DATA, DATA_HOLD, DONE), default `PHASE_CYC`/`HOLD_CYC` constants, and the idle strobe value (1).
- One sub-module, `rtc_phase_timer`: loadable 8-bit down-counter with a `zero` flag. The FSM and output registers live in the top module.

## Test plan
- Write, PHASE_CYC=4, HOLD_CYC=2, addr=0x21, wdata=0x59, start at edge 0 -> ADDR drives 0x21 with `a_d`=`cs`=`wr`=0 for 4 cycles, then 2 hold cycles, then `wr`=0 with 0x59 for 4 cycles, then 2 hold cycles. `done` is high in cycle 13. `rdata` is unchanged.
- Read, addr=0x22, `dato_in`=0x37 during DATA -> `rd`=0 for 4 cycles, `dato_oe`=0 throughout DATA/DATA_HOLD, `rdata`=0x37 when `done` is high. `wr` stays 1.
- `start` held high continuously -> cycles repeat with exactly one IDLE cycle between `done` and the next ADDR. Address and data are re-latched each time.
- `start` pulse during DATA with changed addr -> in-flight cycle uses the original addr. With `RTC_BUS_BUSY_ERR_EN`, `err`=1 for one cycle; without it, `err`=0.
- `reset` low in the middle of ADDR_HOLD -> strobes 1, `dato_oe`=0, `busy`=0 with no clock edge required. After release, the next `start` runs a full cycle normally.
- PHASE_CYC=1, HOLD_CYC=1 -> `done` is high 5 cycles after start acceptance, and every phase lasts exactly 1 cycle.

Source files
------------

// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed bus cycle engine.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_HOLD = 3'd2,
    ST_DATA      = 3'd3,
    ST_DATA_HOLD = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  localparam int unsigned PHASE_CYC_DEF = 32'd10;
  localparam int unsigned HOLD_CYC_DEF  = 32'd4;

  // Inactive level of the active-low RTC strobes.
  localparam logic STROBE_IDLE = 1'b1;

  // Phase timer reload value for a phase lasting n cycles.
  function automatic logic [7:0] cyc_to_load(input int unsigned n);
    return 8'(n - 32'd1);
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable 8-bit down-counter timing one bus phase.
// zero_o flags the final cycle of the current phase; zero_next_o predicts
// the flag for the following cycle so the caller can register outputs early.
module rtc_phase_timer (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       zero_o,
  output logic       zero_next_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: reload on phase entry, otherwise count down and stop at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o      = (cnt_q == 8'd0);
  assign zero_next_o = (cnt_d == 8'd0);

endmodule

// File: rtl/rtc_bus_cycle_engine.sv
// One multiplexed address/data bus cycle to the RTC per accepted request.
// All pin-facing outputs are registered and decoded from the next state.
// Optional feature macro: RTC_BUS_BUSY_ERR_EN (err pulse on start while busy).
module rtc_bus_cycle_engine
  import rtc_bus_pkg::*;
#(
  parameter int unsigned PHASE_CYC = PHASE_CYC_DEF,
  parameter int unsigned HOLD_CYC  = HOLD_CYC_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       w_r_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] dato_in_i,
  output logic [7:0] dato_out_o,
  output logic       dato_oe_o,
  output logic       a_d_o,
  output logic       cs_o,
  output logic       rd_o,
  output logic       wr_o,
  output logic [7:0] rdata_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam logic [7:0] PHASE_LOAD = cyc_to_load(PHASE_CYC);
  localparam logic [7:0] HOLD_LOAD  = cyc_to_load(HOLD_CYC);

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       w_r_q, w_r_d;
  logic       a_d_q, a_d_d, cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
  logic       oe_q, oe_d, busy_q, busy_d, done_q, done_d;
  logic [7:0] dout_q, dout_d, rdata_q, rdata_d;

  logic       tmr_load;
  logic [7:0] tmr_val;
  logic       tmr_zero, tmr_zero_next;

  rtc_phase_timer u_timer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (tmr_load),
    .load_val_i  (tmr_val),
    .zero_o      (tmr_zero),
    .zero_next_o (tmr_zero_next)
  );

  // Next-state, request latching and phase timer reloads.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    w_r_d    = w_r_q;
    tmr_load = 1'b0;
    tmr_val  = 8'd0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_ADDR;
          addr_d   = addr_i;
          wdata_d  = wdata_i;
          w_r_d    = w_r_i;
          tmr_load = 1'b1;
          tmr_val  = PHASE_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (tmr_zero) begin
          state_d  = ST_ADDR_HOLD;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LOAD;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_ADDR_HOLD: begin
        if (tmr_zero) begin
          state_d  = ST_DATA;
          tmr_load = 1'b1;
          tmr_val  = PHASE_LOAD;
        end else begin
          state_d = ST_ADDR_HOLD;
        end
      end
      ST_DATA: begin
        if (tmr_zero) begin
          state_d  = ST_DATA_HOLD;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LOAD;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DATA_HOLD: begin
        if (tmr_zero) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DATA_HOLD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin values for the coming cycle, decoded from the next state. On reads
  // the address is released in the last address-hold cycle so the bus is
  // already turned around before rd falls.
  always_comb begin
    a_d_d  = STROBE_IDLE;
    cs_d   = STROBE_IDLE;
    rd_d   = STROBE_IDLE;
    wr_d   = STROBE_IDLE;
    oe_d   = 1'b0;
    dout_d = 8'd0;
    done_d = 1'b0;
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_ADDR: begin
        a_d_d  = 1'b0;
        cs_d   = 1'b0;
        wr_d   = 1'b0;
        oe_d   = 1'b1;
        dout_d = addr_d;
      end
      ST_ADDR_HOLD: begin
        a_d_d  = 1'b0;
        oe_d   = w_r_d | ~tmr_zero_next;
        dout_d = addr_d;
      end
      ST_DATA: begin
        cs_d = 1'b0;
        if (w_r_d) begin
          wr_d   = 1'b0;
          oe_d   = 1'b1;
          dout_d = wdata_d;
        end else begin
          rd_d = 1'b0;
        end
      end
      ST_DATA_HOLD: begin
        if (w_r_d) begin
          oe_d   = 1'b1;
          dout_d = wdata_d;
        end else begin
          oe_d = 1'b0;
        end
      end
      ST_DONE: done_d = 1'b1;
      default: done_d = 1'b0;
    endcase
  end

  // Read byte is captured on the edge that closes the read data phase.
  always_comb begin
    if ((state_q == ST_DATA) && tmr_zero && !w_r_q) begin
      rdata_d = dato_in_i;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= 8'd0;
      wdata_q <= 8'd0;
      w_r_q   <= 1'b0;
      a_d_q   <= STROBE_IDLE;
      cs_q    <= STROBE_IDLE;
      rd_q    <= STROBE_IDLE;
      wr_q    <= STROBE_IDLE;
      oe_q    <= 1'b0;
      dout_q  <= 8'd0;
      rdata_q <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      w_r_q   <= w_r_d;
      a_d_q   <= a_d_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef RTC_BUS_BUSY_ERR_EN
  logic err_q, err_d;

  // A request arriving while a cycle is in flight is dropped and flagged.
  always_comb begin
    err_d = start_i && (state_q != ST_IDLE);
  end

  // Error pulse register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign dato_out_o = dout_q;
  assign dato_oe_o  = oe_q;
  assign a_d_o      = a_d_q;
  assign cs_o       = cs_q;
  assign rd_o       = rd_q;
  assign wr_o       = wr_q;
  assign rdata_o    = rdata_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_rtc_bus_cycle_engine.sv
// Scoreboard bench for rtc_bus_cycle_engine: two instances (4/2 and 1/1
// phase/hold widths) share one randomized stimulus stream. A cycle-offset
// reference model predicts every pin each cycle; completed requests are
// queued at acceptance and popped when done is seen.
module tb_rtc_bus_cycle_engine;

  localparam int P0 = 4;
  localparam int H0 = 2;
  localparam int P1 = 1;
  localparam int H1 = 1;

  typedef struct {
    logic       w_r;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata_exp;
  } req_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       w_r = 1'b0;
  logic [7:0] addr = 8'd0;
  logic [7:0] wdata = 8'd0;
  logic [7:0] dato_in = 8'd0;

  logic [1:0] a_d_w, cs_w, rd_w, wr_w, oe_w, busy_w, done_w, err_w;
  logic [7:0] dout_w [2];
  logic [7:0] rdata_w [2];

  int checks = 0;
  int errors = 0;

  int         off [2];
  req_t       cur [2];
  logic [7:0] rdata_m [2];
  logic       err_m [2];
  int         done_cnt [2];
  req_t       sb0 [$];
  req_t       sb1 [$];

  always #5 clk = ~clk;

  rtc_bus_cycle_engine #(.PHASE_CYC(P0), .HOLD_CYC(H0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .w_r_i(w_r),
    .addr_i(addr), .wdata_i(wdata), .dato_in_i(dato_in),
    .dato_out_o(dout_w[0]), .dato_oe_o(oe_w[0]), .a_d_o(a_d_w[0]),
    .cs_o(cs_w[0]), .rd_o(rd_w[0]), .wr_o(wr_w[0]), .rdata_o(rdata_w[0]),
    .busy_o(busy_w[0]), .done_o(done_w[0]), .err_o(err_w[0])
  );

  rtc_bus_cycle_engine #(.PHASE_CYC(P1), .HOLD_CYC(H1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .w_r_i(w_r),
    .addr_i(addr), .wdata_i(wdata), .dato_in_i(dato_in),
    .dato_out_o(dout_w[1]), .dato_oe_o(oe_w[1]), .a_d_o(a_d_w[1]),
    .cs_o(cs_w[1]), .rd_o(rd_w[1]), .wr_o(wr_w[1]), .rdata_o(rdata_w[1]),
    .busy_o(busy_w[1]), .done_o(done_w[1]), .err_o(err_w[1])
  );

  function automatic int pcyc(input int i);
    return (i == 0) ? P0 : P1;
  endfunction

  function automatic int hcyc(input int i);
    return (i == 0) ? H0 : H1;
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d @%0t: got %h expected %h", name, inst, $time, act, exp);
    end
  endtask

  task automatic sb_push(input int i, input req_t r);
    if (i == 0) sb0.push_back(r); else sb1.push_back(r);
  endtask

  task automatic sb_clear(input int i);
    if (i == 0) sb0.delete(); else sb1.delete();
  endtask

  task automatic sb_set_last_rdata(input int i, input logic [7:0] v);
    req_t t;
    if (i == 0) begin
      if (sb0.size() > 0) begin t = sb0.pop_back(); t.rdata_exp = v; sb0.push_back(t); end
    end else begin
      if (sb1.size() > 0) begin t = sb1.pop_back(); t.rdata_exp = v; sb1.push_back(t); end
    end
  endtask

  task automatic sb_pop(input int i, output req_t r, output bit ok);
    ok = 1'b0;
    if (i == 0) begin
      if (sb0.size() > 0) begin r = sb0.pop_front(); ok = 1'b1; end
    end else begin
      if (sb1.size() > 0) begin r = sb1.pop_front(); ok = 1'b1; end
    end
  endtask

  // Expected pins for cycle offset o of a request (0 = idle). Order of
  // the packed result: a_d cs rd wr oe busy done.
  function automatic logic [6:0] exp_sig(input int o, input int p, input int h, input req_t r);
    logic a, c, rd, wr, oe;
    a = 1'b1; c = 1'b1; rd = 1'b1; wr = 1'b1; oe = 1'b0;
    if (o >= 1 && o <= p) begin
      a = 1'b0; c = 1'b0; wr = 1'b0; oe = 1'b1;
    end else if (o > p && o <= p + h) begin
      a = 1'b0; oe = r.w_r || (o != p + h);
    end else if (o > p + h && o <= 2 * p + h) begin
      c = 1'b0;
      if (r.w_r) begin wr = 1'b0; oe = 1'b1; end else rd = 1'b0;
    end else if (o > 2 * p + h && o <= 2 * p + 2 * h) begin
      oe = r.w_r;
    end
    return {a, c, rd, wr, oe, (o != 0), (o == 2 * p + 2 * h + 1)};
  endfunction

  function automatic logic [7:0] exp_dout(input int o, input int p, input int h, input req_t r);
    return (o <= p + h) ? r.addr : r.wdata;
  endfunction

  // Reference model: request acceptance, cycle position, read capture, err.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        off[i] = 0; rdata_m[i] = 8'd0; err_m[i] = 1'b0;
        sb_clear(i);
      end else begin
        err_m[i] = 1'b0;
        if (off[i] == 0) begin
          if (start) begin
            cur[i].w_r = w_r; cur[i].addr = addr; cur[i].wdata = wdata;
            cur[i].rdata_exp = rdata_m[i];
            sb_push(i, cur[i]);
            off[i] = 1;
          end
        end else begin
`ifdef RTC_BUS_BUSY_ERR_EN
          err_m[i] = start;
`endif
          if (off[i] == 2 * pcyc(i) + hcyc(i) && !cur[i].w_r) begin
            rdata_m[i] = dato_in;
            sb_set_last_rdata(i, dato_in);
          end
          off[i] = (off[i] == 2 * pcyc(i) + 2 * hcyc(i) + 1) ? 0 : off[i] + 1;
        end
      end
    end
  end

  // Monitor: compare every pin each cycle, pop the scoreboard on done.
  always @(negedge clk) begin
    req_t r;
    bit ok;
    logic [6:0] e;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        e = exp_sig(off[i], pcyc(i), hcyc(i), cur[i]);
        chk("pins{a_d,cs,rd,wr,oe,busy,done}", i,
            {25'd0, a_d_w[i], cs_w[i], rd_w[i], wr_w[i], oe_w[i], busy_w[i], done_w[i]}, {25'd0, e});
        if (e[2]) chk("dato_out", i, {24'd0, dout_w[i]}, {24'd0, exp_dout(off[i], pcyc(i), hcyc(i), cur[i])});
        chk("rdata", i, {24'd0, rdata_w[i]}, {24'd0, rdata_m[i]});
        chk("err", i, {31'd0, err_w[i]}, {31'd0, err_m[i]});
        if (done_w[i]) begin
          done_cnt[i]++;
          sb_pop(i, r, ok);
          chk("done_has_request", i, {31'd0, ok}, 32'd1);
          if (ok) chk("done_rdata", i, {24'd0, rdata_w[i]}, {24'd0, r.rdata_exp});
        end
      end
    end
  end

  task automatic pulse_start(input logic wr_i, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    start = 1'b1; w_r = wr_i; addr = a; wdata = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_off0(input int target, input int budget);
    int n = 0;
    while (off[0] != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_bound", 0, off[0], target);
  endtask

  task automatic check_reset_pins();
    for (int i = 0; i < 2; i++) begin
      chk("rst_strobes", i, {28'd0, a_d_w[i], cs_w[i], rd_w[i], wr_w[i]}, 32'hf);
      chk("rst_oe_busy_done_err", i, {28'd0, oe_w[i], busy_w[i], done_w[i], err_w[i]}, 32'h0);
      chk("rst_dout_rdata", i, {16'd0, dout_w[i], rdata_w[i]}, 32'h0);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) done_cnt[i] = 0;
    repeat (3) @(negedge clk);
    check_reset_pins();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed write then read.
    pulse_start(1'b1, 8'h21, 8'h59);
    wait_off0(0, 40);
    dato_in = 8'h37;
    pulse_start(1'b0, 8'h22, 8'hA5);
    wait_off0(0, 40);

    // start held high: back-to-back cycles with fresh fields every cycle.
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      start = 1'b1; w_r = 1'($urandom_range(0, 1));
      addr = 8'($urandom); wdata = 8'($urandom); dato_in = 8'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    wait_off0(0, 40);

    // Start during DATA with a changed address must not disturb the cycle.
    pulse_start(1'b1, 8'h40, 8'h3C);
    wait_off0(P0 + H0 + 2, 40);
    start = 1'b1; addr = 8'h99; w_r = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_off0(0, 40);

    // Asynchronous reset in the middle of the address hold phase.
    pulse_start(1'b1, 8'h5A, 8'hC3);
    wait_off0(P0 + 1, 40);
    #2 rst_n = 1'b0;
    #1 check_reset_pins();
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    pulse_start(1'b0, 8'h11, 8'h00);
    wait_off0(0, 40);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0); w_r = 1'($urandom_range(0, 1));
      addr = 8'($urandom); wdata = 8'($urandom); dato_in = 8'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    wait_off0(0, 40);
    repeat (5) @(negedge clk);

    chk("sb_empty", 0, sb0.size(), 0);
    chk("sb_empty", 1, sb1.size(), 0);
    for (int i = 0; i < 2; i++) chk("done_seen", i, {31'd0, done_cnt[i] > 10}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
